// File: rtl/k16_fb_pkg.sv
// Shared defaults and state encoding for the K16 framebuffer write path.
package k16_fb_pkg;

  localparam int K16_ADDR_WIDTH = 11;
  localparam int K16_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_e;

endpackage

// File: rtl/k16_fill_gen.sv
// Block-fill address/count/value registers; address wraps modulo 2^ADDR_WIDTH.
module k16_fill_gen
  import k16_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = K16_ADDR_WIDTH,
  parameter int DATA_WIDTH = K16_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH:0]   remain_r;
  logic [DATA_WIDTH-1:0] value_r;

  // Latch a new fill on load, step address and remaining count on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= {ADDR_WIDTH{1'b0}};
      remain_r <= {(ADDR_WIDTH+1){1'b0}};
      value_r  <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      addr_r   <= base;
      remain_r <= count;
      value_r  <= value;
    end else if (advance) begin
      addr_r   <= addr_r + ADDR_ONE;
      remain_r <= remain_r - COUNT_ONE;
    end
  end

  assign addr = addr_r;
  assign data = value_r;
  assign last = (remain_r == COUNT_ONE);

endmodule

// File: rtl/k16_fb_write_arbiter.sv
// Framebuffer write port arbiter: CPU writes take priority over block-fill writes.
module k16_fb_write_arbiter
  import k16_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = K16_ADDR_WIDTH,
  parameter int DATA_WIDTH = K16_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_ack,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_count,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [DATA_WIDTH-1:0] fb_din
);

  localparam logic [ADDR_WIDTH:0] COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

  fb_state_e             state_r, next_state_s;
  logic                  cpu_grant_s, fill_accept_s, load_s, advance_s;
  logic                  we_s, ack_s, done_s, busy_s;
  logic [ADDR_WIDTH-1:0] waddr_s, gen_addr_s;
  logic [DATA_WIDTH-1:0] din_s, gen_data_s;
  logic                  gen_last_s;

  // The registered ack blocks a back-to-back grant, so a held request gets every other slot.
  assign cpu_grant_s   = cpu_req & ~cpu_ack;
  assign fill_accept_s = fill_start & ~fill_busy & (state_r == ST_IDLE);

  k16_fill_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fill_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .advance(advance_s),
    .base   (fill_base),
    .count  (fill_count),
    .value  (fill_value),
    .addr   (gen_addr_s),
    .data   (gen_data_s),
    .last   (gen_last_s)
  );

  // Grant decision and next state.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    we_s         = 1'b0;
    ack_s        = 1'b0;
    done_s       = 1'b0;
    waddr_s      = fb_waddr;
    din_s        = fb_din;
    case (state_r)
      ST_IDLE: begin
        if (cpu_grant_s) begin
          we_s    = 1'b1;
          ack_s   = 1'b1;
          waddr_s = cpu_addr;
          din_s   = cpu_data;
        end else begin
          we_s = 1'b0;
        end
        if (fill_accept_s && (fill_count != COUNT_ZERO)) begin
          load_s       = 1'b1;
          next_state_s = ST_FILL;
        end else if (fill_accept_s) begin
          done_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (cpu_grant_s) begin
          we_s    = 1'b1;
          ack_s   = 1'b1;
          waddr_s = cpu_addr;
          din_s   = cpu_data;
        end else begin
          we_s      = 1'b1;
          advance_s = 1'b1;
          waddr_s   = gen_addr_s;
          din_s     = gen_data_s;
          if (gen_last_s) begin
            done_s       = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_FILL;
          end
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Busy stays high through the cycle that carries the final fill write.
  assign busy_s = (next_state_s == ST_FILL) | (state_r == ST_FILL);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cpu_ack   <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      fb_we     <= 1'b0;
      fb_waddr  <= {ADDR_WIDTH{1'b0}};
      fb_din    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= next_state_s;
      cpu_ack   <= ack_s;
      fill_busy <= busy_s;
      fill_done <= done_s;
      fb_we     <= we_s;
      fb_waddr  <= waddr_s;
      fb_din    <= din_s;
    end
  end

endmodule

// File: tb/tb_k16_fb_write_arbiter.sv
// Randomized self-checking bench: observed write stream versus a transaction-level model.
module tb_k16_fb_write_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int MAXC = 40000;

  typedef struct {
    int          cyc;
    bit          is_cpu;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_ack;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_count;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [DW-1:0] fb_din;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   busy_log [0:MAXC-1];
  wr_t  wr_q[$];
  int   done_q[$];
  int   ack_q[$];
  req_t exp_cpu[$];

  always #5 clk = ~clk;

  k16_fb_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_din(fb_din)
  );

  // Monitor: one sample per cycle, half a period after the active edge.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (cyc < MAXC) busy_log[cyc] = fill_busy;
      if (fb_we === 1'b1) begin
        w.cyc = cyc; w.is_cpu = (cpu_ack === 1'b1); w.addr = fb_waddr; w.data = fb_din;
        wr_q.push_back(w);
      end
      if (fill_done === 1'b1) done_q.push_back(cyc);
      if (cpu_ack === 1'b1) ack_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_q.delete(); done_q.delete(); ack_q.delete(); exp_cpu.delete();
  endtask

  // Raise a new CPU request with random address/data and record it as expected.
  task automatic cpu_new();
    req_t r;
    r.addr = AW'($urandom_range(0, 2047));
    r.data = DW'($urandom_range(0, 65535));
    cpu_addr = r.addr; cpu_data = r.data; cpu_req = 1'b1;
    exp_cpu.push_back(r);
  endtask

  // CPU side of the handshake, evaluated just after each active edge.
  task automatic cpu_agent(input bit allow_new, input int pct);
    if (cpu_req && cpu_ack) begin
      if (allow_new && ($urandom_range(0, 99) < pct)) cpu_new();
      else cpu_req = 1'b0;
    end else if (!cpu_req && allow_new && ($urandom_range(0, 99) < pct)) begin
      cpu_new();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
    #3;
    n_checks++;
    if ({fb_we, cpu_ack, fill_busy, fill_done, fb_waddr, fb_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0", {fb_we, cpu_ack, fill_busy, fill_done, fb_waddr, fb_din});
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_checks++;
    if ({fb_we, cpu_ack, fill_busy, fill_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 0000", {fb_we, cpu_ack, fill_busy, fill_done});
    end
  endtask

  task automatic test_cpu_single();
    int exp_c;
    int budget;
    clear_obs();
    cpu_addr = 11'h028; cpu_data = 16'h3C41; cpu_req = 1'b1;
    exp_c = cyc + 2;
    budget = 0;
    step();
    while (!cpu_ack && budget < 10) begin step(); budget++; end
    cpu_req = 1'b0;
    step(); step(); step();
    n_checks++;
    if (wr_q.size() != 1 || ack_q.size() != 1) begin
      n_fail++;
      $display("FAIL cpu_single_count: got writes=%0d acks=%0d expected 1/1", wr_q.size(), ack_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].addr !== 11'h028 || wr_q[0].data !== 16'h3C41 || !wr_q[0].is_cpu || wr_q[0].cyc != exp_c) begin
        n_fail++;
        $display("FAIL cpu_single_write: got addr=%0h data=%0h cyc=%0d expected 028/3c41/%0d",
                 wr_q[0].addr, wr_q[0].data, wr_q[0].cyc, exp_c);
      end
    end
  endtask

  task automatic test_fill_basic();
    int first;
    int budget;
    int bad;
    clear_obs();
    fill_base = 11'h000; fill_count = 12'd40; fill_value = 16'h2720; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    first = cyc + 2;
    budget = 0;
    while (done_q.size() == 0 && budget < 100) begin step(); budget++; end
    step(); step();
    n_checks++;
    if (wr_q.size() != 40) begin
      n_fail++;
      $display("FAIL fill_basic_count: got %0d expected 40", wr_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 40; i++)
        if (wr_q[i].addr !== AW'(i) || wr_q[i].data !== 16'h2720 || wr_q[i].is_cpu || wr_q[i].cyc != first + i) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL fill_basic_seq: got %0d bad writes expected 0", bad);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != first + 39) begin
      n_fail++;
      $display("FAIL fill_basic_done: got %0d pulses (first at %0d) expected 1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, first + 39);
    end
    n_checks++;
    if (busy_log[first - 1] !== 1'b1 || busy_log[first + 39] !== 1'b1 || busy_log[first + 40] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_basic_busy: got %b%b%b expected 110",
               busy_log[first - 1], busy_log[first + 39], busy_log[first + 40]);
    end
  endtask

  task automatic test_contention();
    int s;
    int budget;
    int win;
    int bad;
    int nfill;
    int k;
    clear_obs();
    cpu_new();
    fill_base = 11'h100; fill_count = 12'd8; fill_value = DW'($urandom_range(0, 65535)); fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    s = cyc + 1;
    budget = 0;
    while ((done_q.size() == 0 || cpu_req) && budget < 80) begin
      cpu_agent(done_q.size() == 0, 100);
      step();
      budget++;
    end
    cpu_req = 1'b0;
    step(); step();
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != s + 15) begin
      n_fail++;
      $display("FAIL contention_done: got %0d pulses expected 1 at %0d", done_q.size(), s + 15);
    end
    win = 0; bad = 0; nfill = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].cyc >= s && wr_q[i].cyc <= s + 15) begin
        if (wr_q[i].cyc != s + win || wr_q[i].is_cpu != ((win % 2) == 0)) bad++;
        win++;
      end
      if (!wr_q[i].is_cpu) begin
        if (wr_q[i].addr !== AW'(11'h100 + nfill) || wr_q[i].data !== fill_value) bad++;
        nfill++;
      end
    end
    n_checks++;
    if (win != 16 || nfill != 8 || bad != 0) begin
      n_fail++;
      $display("FAIL contention_alternate: got window=%0d fill=%0d bad=%0d expected 16/8/0", win, nfill, bad);
    end
    k = 0; bad = 0;
    foreach (wr_q[i]) if (wr_q[i].is_cpu) begin
      if (k >= exp_cpu.size() || wr_q[i].addr !== exp_cpu[k].addr || wr_q[i].data !== exp_cpu[k].data) bad++;
      k++;
    end
    n_checks++;
    if (bad != 0 || k != exp_cpu.size()) begin
      n_fail++;
      $display("FAIL contention_cpu_data: got %0d cpu writes, %0d bad, expected %0d, 0 bad", k, bad, exp_cpu.size());
    end
  endtask

  task automatic test_wrap_zero();
    logic [AW-1:0] exp_a [4];
    int bad;
    int budget;
    int s;
    clear_obs();
    exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000; exp_a[3] = 11'h001;
    fill_base = 11'h7FE; fill_count = 12'd4; fill_value = 16'hA5A5; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    budget = 0;
    while (done_q.size() == 0 && budget < 20) begin step(); budget++; end
    step(); step();
    bad = 0;
    if (wr_q.size() != 4) bad = 100;
    else for (int i = 0; i < 4; i++) if (wr_q[i].addr !== exp_a[i] || wr_q[i].data !== 16'hA5A5) bad++;
    n_checks++;
    if (bad != 0 || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL wrap_seq: got %0d writes, bad=%0d, done=%0d expected 4/0/1", wr_q.size(), bad, done_q.size());
    end
    clear_obs();
    fill_base = AW'($urandom_range(0, 2047)); fill_count = 12'd0; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    s = cyc + 1;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (wr_q.size() != 0 || done_q.size() != 1 || done_q[0] != s || busy_log[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: got writes=%0d done=%0d at %0d busy=%b expected 0/1 at %0d busy 0",
               wr_q.size(), done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, busy_log[s], s);
    end
  endtask

  task automatic test_reset_midfill();
    int budget;
    int bad;
    logic [AW-1:0] b1;
    logic [DW-1:0] v1;
    clear_obs();
    fill_base = AW'($urandom_range(0, 2047)); fill_count = 12'd10; fill_value = 16'h1234; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    budget = 0;
    while (wr_q.size() < 3 && budget < 30) begin @(negedge clk); #1; budget++; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || fill_busy !== 1'b0 || fb_waddr !== '0 || fb_din !== '0) begin
      n_fail++;
      $display("FAIL reset_midfill_immediate: got we=%b busy=%b addr=%0h din=%0h expected 0/0/0/0",
               fb_we, fill_busy, fb_waddr, fb_din);
    end
    step(); step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if (wr_q.size() != 3 || done_q.size() != 0 || fill_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midfill_abandon: got writes=%0d done=%0d busy=%b expected 3/0/0",
               wr_q.size(), done_q.size(), fill_busy);
    end
    clear_obs();
    b1 = AW'($urandom_range(0, 2047)); v1 = DW'($urandom_range(0, 65535));
    fill_base = b1; fill_count = 12'd5; fill_value = v1; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    step();
    fill_base = b1 + 11'd300; fill_count = 12'd3; fill_value = ~v1; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    budget = 0;
    while (done_q.size() == 0 && budget < 30) begin step(); budget++; end
    for (int i = 0; i < 10; i++) step();
    bad = 0;
    if (wr_q.size() != 5) bad = 100;
    else for (int i = 0; i < 5; i++) if (wr_q[i].addr !== AW'(b1 + AW'(i)) || wr_q[i].data !== v1) bad++;
    n_checks++;
    if (bad != 0 || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL start_while_busy: got writes=%0d bad=%0d done=%0d expected 5/0/1", wr_q.size(), bad, done_q.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [AW-1:0] base;
      logic [DW-1:0] val;
      int cnt;
      int pct;
      int s;
      int budget;
      int nf;
      int nc;
      int bad;
      int last_fill;
      int last_cpu;
      clear_obs();
      base = AW'($urandom_range(0, 2047));
      val  = DW'($urandom_range(0, 65535));
      cnt  = (it == 0) ? 2048 : ((it % 5 == 1) ? 0 : $urandom_range(1, 24));
      pct  = $urandom_range(0, 100);
      if ($urandom_range(0, 1) == 1) cpu_new();
      fill_base = base; fill_count = (AW+1)'(cnt); fill_value = val; fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      s = cyc + 1;
      budget = 0;
      while ((done_q.size() == 0 || cpu_req) && budget < 2 * cnt + 60) begin
        cpu_agent(done_q.size() == 0, pct);
        step();
        budget++;
      end
      cpu_req = 1'b0;
      step(); step(); step();
      nf = 0; nc = 0; bad = 0; last_fill = -1; last_cpu = -10;
      foreach (wr_q[i]) begin
        if (wr_q[i].is_cpu) begin
          if (nc >= exp_cpu.size() || wr_q[i].addr !== exp_cpu[nc].addr || wr_q[i].data !== exp_cpu[nc].data) bad++;
          if (wr_q[i].cyc - last_cpu < 2) bad++;
          last_cpu = wr_q[i].cyc;
          nc++;
        end else begin
          if (wr_q[i].addr !== AW'(base + AW'(nf)) || wr_q[i].data !== val) bad++;
          last_fill = wr_q[i].cyc;
          nf++;
        end
      end
      n_checks++;
      if (nf != cnt || nc != exp_cpu.size() || bad != 0) begin
        n_fail++;
        $display("FAIL random_stream it=%0d: got fill=%0d cpu=%0d bad=%0d expected fill=%0d cpu=%0d bad=0",
                 it, nf, nc, bad, cnt, exp_cpu.size());
      end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != ((cnt == 0) ? s : last_fill)) begin
        n_fail++;
        $display("FAIL random_done it=%0d: got %0d pulses first at %0d expected 1 at %0d",
                 it, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, (cnt == 0) ? s : last_fill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_single();
    test_fill_basic();
    test_contention();
    test_wrap_zero();
    test_reset_midfill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/k16_fb_write_arbiter.md
K16_FB_WRITE_ARBITER -- requirements
Module: k16_fb_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, framebuffer word address width.
REQ-002 Parameter DATA_WIDTH, default 16, framebuffer word width: attribute in [15:8], character in [7:0].
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU framebuffer write request; held until cpu_ack.
REQ-006 cpu_addr  input  ADDR_WIDTH  CPU write word address.
REQ-007 cpu_data  input  DATA_WIDTH  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle pulse; CPU write issued.
REQ-009 fill_start  input  1  one-cycle pulse; start a block fill.
REQ-010 fill_base  input  ADDR_WIDTH  first fill address, sampled on fill_start.
REQ-011 fill_count  input  ADDR_WIDTH+1  number of words to fill (0..2048), sampled on fill_start.
REQ-012 fill_value  input  DATA_WIDTH  fill word, sampled on fill_start.
REQ-013 fill_busy  output  1  high while a fill is in progress.
REQ-014 fill_done  output  1  one-cycle pulse at fill completion.
REQ-015 fb_we  output  1  framebuffer RAM write enable.
REQ-016 fb_waddr  output  ADDR_WIDTH  framebuffer RAM write address.
REQ-017 fb_din  output  DATA_WIDTH  framebuffer RAM write data.

Function
REQ-018 The block SHALL have two states: IDLE and FILL.
REQ-019 All outputs SHALL be registered; fb_we/fb_waddr/fb_din are valid in the cycle after the grant decision.
REQ-020 CPU grant condition: cpu_req=1 and cpu_ack=0 at the clock edge; grant produces fb_we=1, fb_waddr=cpu_addr, fb_din=cpu_data and cpu_ack=1 in the following cycle.
REQ-021 A CPU holding cpu_req continuously SHALL therefore receive at most one write per two cycles.
REQ-022 IDLE -> FILL on fill_start with fill_count>0; the fill address/remaining count/value are latched and fill_busy=1 from the next cycle.
REQ-023 fill_start with fill_count=0 SHALL perform no write, leave fill_busy=0, and pulse fill_done in the next cycle.
REQ-024 In FILL, each cycle without a CPU grant SHALL issue one fill write (fb_din=latched value), increment the address and decrement the remaining count; a CPU grant takes that slot and the fill is stalled one cycle.
REQ-025 Fill address SHALL wrap modulo 2^ADDR_WIDTH (0x7FF -> 0x000).
REQ-026 The final fill write SHALL present fill_done=1 in the same cycle as its fb_we; fill_busy SHALL be 0 from the following cycle; state returns to IDLE.
REQ-027 fill_start while fill_busy=1 SHALL be ignored.
REQ-028 Simultaneous cpu_req grant and fill_start in IDLE: the CPU write is issued, and the fill begins as per REQ-022.
REQ-029 fb_we SHALL be 0 in any cycle with neither a CPU grant nor a fill write; fb_waddr/fb_din hold their last values.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, fb_we=0, cpu_ack=0, fill_busy=0, fill_done=0, fb_waddr=0, fb_din=0, and clear the fill registers.
REQ-031 A reset during FILL SHALL abandon the fill with no fill_done pulse; no write occurs after rst_n falls.

Structure
REQ-032 Package k16_fb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and the IDLE/FILL state encoding.
REQ-033 The fill address/count/value registers SHALL be a sub-module k16_fill_gen (load, advance, last outputs); arbitration and output registers stay in the top.

Verification
REQ-034 CPU single write: cpu_req with addr 0x028 and data 0x3C41 -> next cycle fb_we=1, fb_waddr=0x028, fb_din=0x3C41, cpu_ack=1 for exactly one cycle.
REQ-035 Fill: base 0x000, count 40, value 0x2720, no CPU -> 40 consecutive writes to 0x000..0x027, fill_done on the 40th, fill_busy low afterwards.
REQ-036 Contention: fill of 8 words at 0x100 with cpu_req held high throughout -> CPU and fill writes alternate, all 8 fill words written, total 16 write cycles.
REQ-037 Wrap and zero count: base 0x7FE, count 4 -> writes to 0x7FE, 0x7FF, 0x000, 0x001; count 0 -> no fb_we, fill_done one cycle after start.
REQ-038 Reset mid-fill: rst_n low after 3 of 10 writes -> fb_we low immediately, no fill_done, IDLE after release; fill_start during busy is ignored.
